// File: rtl/idex_pipeline_register.sv
`default_nettype none
// ============================================================================
// Module   : idex_pipeline_register
// Purpose  : ID/EX pipeline register for the RV32I 5-stage pipeline. Carries
//            decode-stage control, operand, immediate and PC fields into the
//            execute stage. Async reset clears everything; a synchronous
//            flush loads a NOP bubble whose PCs are tagged for debug.
// Revision : 1.0 - initial release
// ============================================================================
module idex_pipeline_register #(
  parameter logic [31:0] FLUSH_PC_VALUE = 32'h2A2A_2A2A
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Flush_E,
  input  logic        REG_W_En_D,
  input  logic        MEM_W_En_D,
  input  logic        Jump_En_D,
  input  logic        Branch_En_D,
  input  logic [2:0]  MEM_Control_D,
  input  logic [3:0]  ALU_Control_D,
  input  logic        Branch_Src_Sel_D,
  input  logic        ALU_SrcA_Sel_D,
  input  logic        ALU_SrcB_Sel_D,
  input  logic [1:0]  Result_Src_Sel_D,
  input  logic [4:0]  RD_D,
  input  logic [4:0]  RS1_D,
  input  logic [4:0]  RS2_D,
  input  logic [31:0] REG_R_Data1_D,
  input  logic [31:0] REG_R_Data2_D,
  input  logic [31:0] Imm_Ext_D,
  input  logic [31:0] PC_D,
  input  logic [31:0] PC_Plus_4_D,
  output logic        REG_W_En_E,
  output logic        MEM_W_En_E,
  output logic        Jump_En_E,
  output logic        Branch_En_E,
  output logic [2:0]  MEM_Control_E,
  output logic [3:0]  ALU_Control_E,
  output logic        Branch_Src_Sel_E,
  output logic        ALU_SrcA_Sel_E,
  output logic        ALU_SrcB_Sel_E,
  output logic [1:0]  Result_Src_Sel_E,
  output logic [4:0]  RD_E,
  output logic [4:0]  RS1_E,
  output logic [4:0]  RS2_E,
  output logic [31:0] REG_R_Data1_E,
  output logic [31:0] REG_R_Data2_E,
  output logic [31:0] Imm_Ext_E,
  output logic [31:0] PC_E,
  output logic [31:0] PC_Plus_4_E
);

  logic        r_reg_w_en;
  logic        r_mem_w_en;
  logic        r_jump_en;
  logic        r_branch_en;
  logic [2:0]  r_mem_control;
  logic [3:0]  r_alu_control;
  logic        r_branch_src_sel;
  logic        r_alu_srca_sel;
  logic        r_alu_srcb_sel;
  logic [1:0]  r_result_src_sel;
  logic [4:0]  r_rd;
  logic [4:0]  r_rs1;
  logic [4:0]  r_rs2;
  logic [31:0] r_reg_r_data1;
  logic [31:0] r_reg_r_data2;
  logic [31:0] r_imm_ext;
  logic [31:0] r_pc;
  logic [31:0] r_pc_plus_4;

  // Stage register: reset clears all, flush inserts a tagged bubble, else load.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_reg_w_en       <= 1'b0;
      r_mem_w_en       <= 1'b0;
      r_jump_en        <= 1'b0;
      r_branch_en      <= 1'b0;
      r_mem_control    <= 3'd0;
      r_alu_control    <= 4'd0;
      r_branch_src_sel <= 1'b0;
      r_alu_srca_sel   <= 1'b0;
      r_alu_srcb_sel   <= 1'b0;
      r_result_src_sel <= 2'd0;
      r_rd             <= 5'd0;
      r_rs1            <= 5'd0;
      r_rs2            <= 5'd0;
      r_reg_r_data1    <= 32'd0;
      r_reg_r_data2    <= 32'd0;
      r_imm_ext        <= 32'd0;
      r_pc             <= 32'd0;
      r_pc_plus_4      <= 32'd0;
    end else if (Flush_E) begin
      // Bubble: no side effects downstream; PCs carry a recognisable marker.
      r_reg_w_en       <= 1'b0;
      r_mem_w_en       <= 1'b0;
      r_jump_en        <= 1'b0;
      r_branch_en      <= 1'b0;
      r_mem_control    <= 3'd0;
      r_alu_control    <= 4'd0;
      r_branch_src_sel <= 1'b0;
      r_alu_srca_sel   <= 1'b0;
      r_alu_srcb_sel   <= 1'b0;
      r_result_src_sel <= 2'd0;
      r_rd             <= 5'd0;
      r_rs1            <= 5'd0;
      r_rs2            <= 5'd0;
      r_reg_r_data1    <= 32'd0;
      r_reg_r_data2    <= 32'd0;
      r_imm_ext        <= 32'd0;
      r_pc             <= FLUSH_PC_VALUE;
      r_pc_plus_4      <= FLUSH_PC_VALUE;
    end else begin
      r_reg_w_en       <= REG_W_En_D;
      r_mem_w_en       <= MEM_W_En_D;
      r_jump_en        <= Jump_En_D;
      r_branch_en      <= Branch_En_D;
      r_mem_control    <= MEM_Control_D;
      r_alu_control    <= ALU_Control_D;
      r_branch_src_sel <= Branch_Src_Sel_D;
      r_alu_srca_sel   <= ALU_SrcA_Sel_D;
      r_alu_srcb_sel   <= ALU_SrcB_Sel_D;
      r_result_src_sel <= Result_Src_Sel_D;
      r_rd             <= RD_D;
      r_rs1            <= RS1_D;
      r_rs2            <= RS2_D;
      r_reg_r_data1    <= REG_R_Data1_D;
      r_reg_r_data2    <= REG_R_Data2_D;
      r_imm_ext        <= Imm_Ext_D;
      r_pc             <= PC_D;
      r_pc_plus_4      <= PC_Plus_4_D;
    end
  end

  assign REG_W_En_E       = r_reg_w_en;
  assign MEM_W_En_E       = r_mem_w_en;
  assign Jump_En_E        = r_jump_en;
  assign Branch_En_E      = r_branch_en;
  assign MEM_Control_E    = r_mem_control;
  assign ALU_Control_E    = r_alu_control;
  assign Branch_Src_Sel_E = r_branch_src_sel;
  assign ALU_SrcA_Sel_E   = r_alu_srca_sel;
  assign ALU_SrcB_Sel_E   = r_alu_srcb_sel;
  assign Result_Src_Sel_E = r_result_src_sel;
  assign RD_E             = r_rd;
  assign RS1_E            = r_rs1;
  assign RS2_E            = r_rs2;
  assign REG_R_Data1_E    = r_reg_r_data1;
  assign REG_R_Data2_E    = r_reg_r_data2;
  assign Imm_Ext_E        = r_imm_ext;
  assign PC_E             = r_pc;
  assign PC_Plus_4_E      = r_pc_plus_4;

endmodule
`default_nettype wire

// File: tb/tb_idex_pipeline_register.sv
`default_nettype none
// ============================================================================
// Module   : tb_idex_pipeline_register
// Purpose  : Self-checking bench for idex_pipeline_register: vector table,
//            expected-value queue, and hand-written reset/flush sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_idex_pipeline_register;

  typedef struct packed {
    logic        reg_w;
    logic        mem_w;
    logic        jump;
    logic        branch;
    logic [2:0]  mem_ctl;
    logic [3:0]  alu_ctl;
    logic        br_src;
    logic        srca;
    logic        srcb;
    logic [1:0]  res_src;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] pc4;
  } fields_t;

  typedef struct {
    fields_t in;
    logic    flush;
    fields_t exp;
    string   name;
  } vec_t;

  logic    CLK = 1'b0;
  logic    RST = 1'b1;
  logic    Flush_E = 1'b0;
  fields_t d = '0;

  logic        o_reg_w, o_mem_w, o_jump, o_branch, o_br_src, o_srca, o_srcb;
  logic [2:0]  o_mem_ctl;
  logic [3:0]  o_alu_ctl;
  logic [1:0]  o_res_src;
  logic [4:0]  o_rd, o_rs1, o_rs2;
  logic [31:0] o_rd1, o_rd2, o_imm, o_pc, o_pc4;
  fields_t     q;

  int n_checks = 0;
  int n_fail   = 0;
  fields_t sb[$];
  vec_t    vecs[8];

  assign q = {o_reg_w, o_mem_w, o_jump, o_branch, o_mem_ctl, o_alu_ctl, o_br_src,
              o_srca, o_srcb, o_res_src, o_rd, o_rs1, o_rs2, o_rd1, o_rd2,
              o_imm, o_pc, o_pc4};

  idex_pipeline_register #(.FLUSH_PC_VALUE(32'h2A2A_2A2A)) dut (
    .CLK(CLK), .RST(RST), .Flush_E(Flush_E),
    .REG_W_En_D(d.reg_w), .MEM_W_En_D(d.mem_w), .Jump_En_D(d.jump),
    .Branch_En_D(d.branch), .MEM_Control_D(d.mem_ctl), .ALU_Control_D(d.alu_ctl),
    .Branch_Src_Sel_D(d.br_src), .ALU_SrcA_Sel_D(d.srca), .ALU_SrcB_Sel_D(d.srcb),
    .Result_Src_Sel_D(d.res_src), .RD_D(d.rd), .RS1_D(d.rs1), .RS2_D(d.rs2),
    .REG_R_Data1_D(d.rd1), .REG_R_Data2_D(d.rd2), .Imm_Ext_D(d.imm),
    .PC_D(d.pc), .PC_Plus_4_D(d.pc4),
    .REG_W_En_E(o_reg_w), .MEM_W_En_E(o_mem_w), .Jump_En_E(o_jump),
    .Branch_En_E(o_branch), .MEM_Control_E(o_mem_ctl), .ALU_Control_E(o_alu_ctl),
    .Branch_Src_Sel_E(o_br_src), .ALU_SrcA_Sel_E(o_srca), .ALU_SrcB_Sel_E(o_srcb),
    .Result_Src_Sel_E(o_res_src), .RD_E(o_rd), .RS1_E(o_rs1), .RS2_E(o_rs2),
    .REG_R_Data1_E(o_rd1), .REG_R_Data2_E(o_rd2), .Imm_Ext_E(o_imm),
    .PC_E(o_pc), .PC_Plus_4_E(o_pc4)
  );

  always #5 CLK = ~CLK;

  // Bubble expected after a flush: everything zero except the tagged PCs.
  function automatic fields_t bubble();
    fields_t b;
    b     = '0;
    b.pc  = 32'h2A2A_2A2A;
    b.pc4 = 32'h2A2A_2A2A;
    return b;
  endfunction

  function automatic fields_t rand_fields();
    fields_t f;
    f.reg_w   = 1'($urandom);
    f.mem_w   = 1'($urandom);
    f.jump    = 1'($urandom);
    f.branch  = 1'($urandom);
    f.mem_ctl = 3'($urandom);
    f.alu_ctl = 4'($urandom);
    f.br_src  = 1'($urandom);
    f.srca    = 1'($urandom);
    f.srcb    = 1'($urandom);
    f.res_src = 2'($urandom);
    f.rd      = 5'($urandom_range(1, 31));
    f.rs1     = 5'($urandom_range(1, 31));
    f.rs2     = 5'($urandom_range(1, 31));
    f.rd1     = $urandom;
    f.rd2     = $urandom;
    f.imm     = $urandom;
    f.pc      = $urandom | 32'h1;
    f.pc4     = $urandom | 32'h1;
    return f;
  endfunction

  task automatic check(input string name, input fields_t exp);
    n_checks++;
    if (q !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, q, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic step(input fields_t in, input logic fl, input fields_t exp, input string name);
    @(negedge CLK);
    d       = in;
    Flush_E = fl;
    sb.push_back(exp);
    @(posedge CLK);
    #1;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, got %h expected an entry", name, q);
    end else begin
      check(name, sb.pop_front());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    fields_t f;

    // Reset state while RST held from time zero
    d = rand_fields();
    repeat (2) @(posedge CLK);
    #1;
    check("reset_state", '0);

    // Reset release: first edge loads inputs
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 5; i++) begin
      f = rand_fields();
      if (i == 0) begin
        f.pc      = 32'h1234_5678;
        f.alu_ctl = 4'hA;
      end
      step(f, 1'b0, f, "pre_reset_load");
    end

    // Async reset between edges: outputs clear without a clock edge
    @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    check("async_reset", '0);
    @(posedge CLK);
    #1;
    check("reset_held", '0);

    // Reset and flush together: reset wins, PCs are 0 not the flush tag
    @(negedge CLK);
    Flush_E = 1'b1;
    d = rand_fields();
    @(posedge CLK);
    #1;
    check("reset_vs_flush", '0);

    // First edge after release with flush still high loads the bubble
    @(negedge CLK);
    RST = 1'b0;
    sb.push_back(bubble());
    @(posedge CLK);
    #1;
    check("release_into_flush", sb.pop_front());

    // Table-driven vectors
    f = '0;
    f.reg_w = 1'b1; f.mem_ctl = 3'b101; f.rd = 5'd17; f.rd1 = 32'hDEAD_BEEF;
    f.imm = 32'hFFFF_F800; f.pc = 32'h100; f.pc4 = 32'h104;
    vecs[0] = '{in: f, flush: 1'b0, exp: f, name: "passthrough"};
    f = '1;
    vecs[1] = '{in: f, flush: 1'b0, exp: f, name: "all_ones"};
    f = rand_fields();
    vecs[2] = '{in: f, flush: 1'b1, exp: bubble(), name: "flush"};
    f = rand_fields();
    vecs[3] = '{in: f, flush: 1'b0, exp: f, name: "after_flush"};
    f = '1;
    vecs[4] = '{in: f, flush: 1'b1, exp: bubble(), name: "flush_all_ones"};
    f = '0;
    vecs[5] = '{in: f, flush: 1'b0, exp: f, name: "all_zero"};
    f = rand_fields();
    vecs[6] = '{in: f, flush: 1'b0, exp: f, name: "random_a"};
    f = rand_fields();
    vecs[7] = '{in: f, flush: 1'b0, exp: f, name: "random_b"};
    for (int i = 0; i < 8; i++)
      step(vecs[i].in, vecs[i].flush, vecs[i].exp, vecs[i].name);

    // Random streaming
    for (int i = 0; i < 8; i++) begin
      f = rand_fields();
      step(f, 1'b0, f, "stream");
    end

    // Back-to-back flush for three edges, then resume
    for (int i = 0; i < 3; i++)
      step(rand_fields(), 1'b1, bubble(), "flush_b2b");
    f = rand_fields();
    step(f, 1'b0, f, "resume_after_b2b");
    f = rand_fields();
    step(f, 1'b0, f, "resume_next");

    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/idex_pipeline_register.md
Name: idex_pipeline_register

Overview:
Decode-to-Execute (ID/EX) pipeline register of the RV32I 5-stage pipelined processor. Captures Decode-stage control, register-file, immediate and PC signals on each rising clock edge and presents them to the Execute stage. Supports asynchronous reset, and a synchronous flush that inserts a NOP bubble for control/load-use hazards. There is no stall input; the register loads every cycle unless reset or flushed.

Parameters:
FLUSH_PC_VALUE, 32'h2A2A_2A2A, value loaded into PC_E and PC_Plus_4_E on flush; marks a bubble for debug.

Ports:
CLK  in  1  clock, rising-edge active
RST  in  1  asynchronous, active-high reset
Flush_E  in  1  synchronous flush; inserts a NOP
REG_W_En_D / REG_W_En_E  in/out  1  register-file write enable
MEM_W_En_D / MEM_W_En_E  in/out  1  data-memory write enable
Jump_En_D / Jump_En_E  in/out  1  jump instruction flag
Branch_En_D / Branch_En_E  in/out  1  branch instruction flag
MEM_Control_D / MEM_Control_E  in/out  3  memory access width/sign control
ALU_Control_D / ALU_Control_E  in/out  4  ALU operation select
Branch_Src_Sel_D / Branch_Src_Sel_E  in/out  1  branch target source select
ALU_SrcA_Sel_D / ALU_SrcA_Sel_E  in/out  1  ALU operand A select
ALU_SrcB_Sel_D / ALU_SrcB_Sel_E  in/out  1  ALU operand B select
Result_Src_Sel_D / Result_Src_Sel_E  in/out  2  writeback result select
RD_D, RS1_D, RS2_D / RD_E, RS1_E, RS2_E  in/out  5 each  destination and source register indices
REG_R_Data1_D, REG_R_Data2_D / REG_R_Data1_E, REG_R_Data2_E  in/out  32 each  register-file read data
Imm_Ext_D / Imm_Ext_E  in/out  32  sign-extended immediate
PC_D / PC_E  in/out  32  instruction PC
PC_Plus_4_D / PC_Plus_4_E  in/out  32  PC + 4

Behaviour:
- All outputs are registered. There is no combinational path from any input to any output.
- Priority order: RST > Flush_E > normal load.
- RST=1, asynchronous: all outputs go to 0 immediately, without waiting for a clock edge. This includes PC_E=0 and PC_Plus_4_E=0. Outputs stay 0 while RST is held high.
- RST=0, Flush_E=1 at a rising edge, all outputs load 0 except:
  - PC_E = FLUSH_PC_VALUE
  - PC_Plus_4_E = FLUSH_PC_VALUE
  - The result is a NOP: no register write, no memory write, no jump, no branch.
- RST=0, Flush_E=0 at a rising edge: every *_E output loads the corresponding *_D input sampled at that edge. Latency is exactly 1 cycle.
- Flush lasts only one cycle. On the edge after Flush_E deasserts, normal loading resumes.
- Simultaneous RST and Flush_E: reset wins, and PC_E and PC_Plus_4_E are 0.
- Reset release: the first edge with RST=0 loads either the inputs or the flush values, as selected by Flush_E.
- No width conversion is performed; all fields pass through bit-exact.
- Inputs that are X or uninitialised before the first load are not required to be handled. Outputs are defined from reset onward.

Test Plan:
- Reset:
  - Drive random inputs (e.g. PC_D=0x1234_5678, ALU_Control_D=4'hA) for 5 cycles.
  - Assert RST between clock edges.
  - Required: all outputs read 0 before the next edge, including PC_E=0, PC_Plus_4_E=0 and Imm_Ext_E=0.
- Pass-through:
  - RST=0, Flush_E=0.
  - Drive REG_W_En_D=1, MEM_Control_D=3'b101, RD_D=5'd17, REG_R_Data1_D=0xDEAD_BEEF, Imm_Ext_D=0xFFFF_F800, PC_D=0x100, PC_Plus_4_D=0x104.
  - Required: exactly one edge later, each *_E output equals the value driven on its *_D input.
- Flush:
  - With random valid inputs, pulse Flush_E=1 for one edge.
  - Required next cycle:
    - PC_E = 0x2A2A_2A2A and PC_Plus_4_E = 0x2A2A_2A2A.
    - All enables, controls, selects, RD/RS1/RS2, REG_R_Data1/REG_R_Data2 and Imm_Ext = 0.
  - On the following edge, outputs again track the inputs.
- Reset vs flush:
  - Assert RST=1 and Flush_E=1 together.
  - Required: all outputs 0, and PC_E=0 (not 0x2A2A_2A2A).
- Random streaming:
  - 5+ cycles of $urandom stimulus with no control signals active.
  - Required: every cycle, each output equals its input from the previous cycle.
- Back-to-back flush:
  - Hold Flush_E=1 for 3 edges.
  - Required: bubble values on every one of those edges. After deassertion, the first loaded value equals the inputs present at that edge.
